pdh_gpio_initiator: RTL and testbench
=====================================

PDH_GPIO_INITIATOR -- requirements
Module: pdh_gpio_initiator

Interface
REQ-001 SHALL have parameter STROBE_LOW_CYCLES, default 2; minimum cycles the command word is held with strobe low before strobe rises.
REQ-002 SHALL have parameter RSP_DELAY, default 4; cycles after strobe rises before the callback compare is enabled.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024; cycles after strobe rises before the transaction is abandoned.
REQ-004 SHALL have parameter RST_HOLD, default 4; cycles that the core-reset bit is held high.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_ni  in  1  synchronous active-low reset.
REQ-008 cmd_valid_i  in  1  command request valid.
REQ-009 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-010 cmd_op_i  in  4  command opcode: 0 IDLE, 1 SET_LED, 2 SET_DAC, 3 GET_ADC, 4 CHECK_SIGNED, 5 SET_ROT_COEFFS, 6 COMMIT_ROT_COEFFS.
REQ-011 cmd_data_i  in  26  command payload.
REQ-012 core_rst_i  in  1  request to pulse the core reset bit.
REQ-013 gpio_to_core_o  out  32  word driven to core: [31] core reset, [30] strobe, [29:26] op, [25:0] data.
REQ-014 gpio_from_core_i  in  32  core callback word; [31:28] echoes the op.
REQ-015 rsp_valid_o  out  1  response valid.
REQ-016 rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
REQ-017 rsp_data_o  out  32  captured callback word.
REQ-018 rsp_timeout_o  out  1  response produced by timeout, not by a match.
REQ-019 busy_o  out  1  high in every state except IDLE.

Function
REQ-020 SHALL implement the states IDLE, SETUP, STROBE, RESP and CRST.
REQ-021 cmd_ready_o SHALL be high only in IDLE with core_rst_i low; a handshake latches op and data and moves to SETUP.
REQ-022 In IDLE, core_rst_i SHALL take priority over cmd_valid_i: move to CRST and accept no command that cycle.
REQ-023 SETUP SHALL drive {0,0,op,data} for exactly STROBE_LOW_CYCLES cycles, then move to STROBE.
REQ-024 STROBE SHALL drive {0,1,op,data}, with op and data unchanged from SETUP, and SHALL run a counter that starts at 0 on entry.
REQ-025 In STROBE, once the counter is >= RSP_DELAY and gpio_from_core_i[31:28]==op, SHALL register gpio_from_core_i into rsp_data_o, clear rsp_timeout_o and move to RESP.
REQ-026 In STROBE, when the counter reaches TIMEOUT_CYCLES with no match, SHALL register gpio_from_core_i into rsp_data_o, set rsp_timeout_o and move to RESP; a match in that same cycle wins and clears the timeout flag.
REQ-027 RESP SHALL drive {0,0,op,data} and assert rsp_valid_o; rsp_data_o and rsp_timeout_o SHALL stay stable until rsp_ready_i is seen.
REQ-028 On the rsp_ready_i handshake, SHALL return to IDLE; rsp_valid_o SHALL fall the next cycle.
REQ-029 CRST SHALL drive 0x80000000 for RST_HOLD cycles, then drive 0x00000000 and return to IDLE; no response is produced.
REQ-030 In IDLE, gpio_to_core_o SHALL hold the last op and data with bits [31:30]=0.
REQ-031 The strobe bit SHALL always be low for >= STROBE_LOW_CYCLES between two rises, so every command gives exactly one rising edge.
REQ-032 The counter SHALL saturate and never wrap.
REQ-033 All outputs SHALL be registered; latency from cmd handshake to strobe rise SHALL be STROBE_LOW_CYCLES+1 cycles.

Reset
REQ-034 While rst_ni=0 at a clock edge: state IDLE, gpio_to_core_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_timeout_o=0, busy_o=0, counters 0.
REQ-035 Reset in any state, including mid-STROBE or mid-CRST, SHALL abort with no response; cmd_ready_o SHALL rise the first cycle after rst_ni=1.

Verification
REQ-036 SET_LED op=1 data=0xA5, core model echoes 0x100000A5 three cycles after strobe -> gpio_to_core_o=0x040000A5, then 0x440000A5; rsp_data_o=0x100000A5, rsp_timeout_o=0.
REQ-037 Back-to-back SET_DAC data=0x4ABC then 0x0123 -> two distinct strobe rises, strobe low >= 2 cycles between them, two responses in order.
REQ-038 TIMEOUT_CYCLES=16, core model returns 0x00000000 for op=3 -> rsp_valid_o rises 16 cycles after strobe rise, rsp_timeout_o=1, rsp_data_o=0.
REQ-039 rsp_ready_i held low 10 cycles -> rsp_valid_o, rsp_data_o and rsp_timeout_o stable, cmd_ready_o=0 throughout.
REQ-040 core_rst_i and cmd_valid_i asserted together in IDLE -> gpio_to_core_o=0x80000000 for 4 cycles; the command is accepted only after return to IDLE.
REQ-041 rst_ni pulled low during STROBE -> next cycle all outputs 0, no rsp_valid_o pulse.

Source files
------------

// File: rtl/pdh_gpio_initiator_if.sv
// Host-side command/response channel of the PDH GPIO initiator.
// Signal names carry the direction as seen by the initiator (the slave
// modport): _i are driven by the host, _o by the initiator.
//   cmd_valid_i / cmd_ready_o  : command handshake
//   cmd_op_i [3:0]             : opcode (0 IDLE .. 6 COMMIT_ROT_COEFFS)
//   cmd_data_i [25:0]          : payload
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_data_o [31:0]          : captured callback word
//   rsp_timeout_o              : response produced by timeout, not a match
interface pdh_gpio_initiator_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [3:0]  cmd_op_i;
    logic [25:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_timeout_o
    );
endinterface

// File: rtl/pdh_gpio_initiator.sv
// PDH GPIO initiator: turns host commands into a strobed 32-bit GPIO word
// for the core and waits for the core's callback word, which must echo the
// opcode in [31:28]. Also pulses a core-reset bit on request.
// Ports:
//   clk, rst_ni         : clock, synchronous active-low reset
//   host (slave)        : command/response channel (pdh_gpio_initiator_if)
//   core_rst_i          : request a core-reset pulse (wins over a command)
//   gpio_to_core_o      : [31] core reset, [30] strobe, [29:26] op, [25:0] data
//   gpio_from_core_i    : callback word from the core
//   busy_o              : high whenever not IDLE
// Every output comes straight from a flop; output flops are loaded with the
// value belonging to the next state.
module pdh_gpio_initiator #(
    parameter int unsigned STROBE_LOW_CYCLES = 2,
    parameter int unsigned RSP_DELAY         = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter int unsigned RST_HOLD          = 4
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    pdh_gpio_initiator_if.slave  host,
    input  logic                 core_rst_i,
    output logic [31:0]          gpio_to_core_o,
    input  logic [31:0]          gpio_from_core_i,
    output logic                 busy_o
);
    // One counter serves SETUP, STROBE and CRST; size it for the largest.
    localparam int unsigned MAX_AB  = (STROBE_LOW_CYCLES > RST_HOLD) ? STROBE_LOW_CYCLES : RST_HOLD;
    localparam int unsigned MAX_CD  = (TIMEOUT_CYCLES > RSP_DELAY) ? TIMEOUT_CYCLES : RSP_DELAY;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((STROBE_LOW_CYCLES > 0) ? STROBE_LOW_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CRST_LAST  = CNT_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] RSP_EN     = CNT_W'(RSP_DELAY);
    // Deciding on the timeout in the STROBE cycle with count TIMEOUT_CYCLES-1
    // makes the response appear exactly TIMEOUT_CYCLES cycles after the rise.
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RESP,
        S_CRST
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [25:0]       data_q, data_d;
    logic [31:0]       gpio_q, gpio_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_match;

    assign rsp_match = (cnt_q >= RSP_EN) && (gpio_from_core_i[31:28] == op_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1); // saturates, never wraps
        op_d          = op_q;
        data_d        = data_q;
        gpio_d        = gpio_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                gpio_d = {2'b00, gpio_q[29:0]};
                if (core_rst_i) begin
                    // Core reset wins; a command offered this cycle is not taken.
                    state_d = S_CRST;
                    gpio_d  = 32'h8000_0000;
                end else if (host.cmd_valid_i && cmd_ready_q) begin
                    state_d = S_SETUP;
                    op_d    = host.cmd_op_i;
                    data_d  = host.cmd_data_i;
                    gpio_d  = {2'b00, host.cmd_op_i, host.cmd_data_i};
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                    gpio_d  = {2'b01, op_q, data_q};
                end
            end
            S_STROBE: begin
                // A match in the timeout cycle still counts as a match.
                if (rsp_match || (cnt_q == TO_LAST)) begin
                    state_d       = S_RESP;
                    rsp_data_d    = gpio_from_core_i;
                    rsp_timeout_d = !rsp_match;
                    gpio_d        = {2'b00, op_q, data_q};
                end
            end
            S_RESP: begin
                if (host.rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_CRST: begin
                if (cnt_q == CRST_LAST) begin
                    state_d = S_IDLE;
                    gpio_d  = 32'h0000_0000;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            data_q        <= '0;
            gpio_q        <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            data_q        <= data_d;
            gpio_q        <= gpio_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign gpio_to_core_o     = gpio_q;
    assign host.cmd_ready_o   = cmd_ready_q;
    assign host.rsp_valid_o   = rsp_valid_q;
    assign host.rsp_data_o    = rsp_data_q;
    assign host.rsp_timeout_o = rsp_timeout_q;
    assign busy_o             = busy_q;
endmodule

// File: tb/tb_pdh_gpio_initiator.sv
// Self-checking bench for pdh_gpio_initiator. The model predicts a timeline
// of expected outputs per cycle from the command rules (phase lengths, first
// matching callback, timeout), and a negedge process compares against it.
module tb_pdh_gpio_initiator;
    localparam int L    = 2;
    localparam int RD   = 4;
    localparam int TO   = 16;
    localparam int RH   = 4;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_rst_i = 1'b0;
    logic [31:0] gpio_from_core_i = 32'h0;
    logic [31:0] gpio_to_core_o;
    logic        busy_o;

    pdh_gpio_initiator_if host_if ();

    pdh_gpio_initiator #(
        .STROBE_LOW_CYCLES(L),
        .RSP_DELAY        (RD),
        .TIMEOUT_CYCLES   (TO),
        .RST_HOLD         (RH)
    ) dut (
        .clk             (clk),
        .rst_ni          (rst_ni),
        .host            (host_if),
        .core_rst_i      (core_rst_i),
        .gpio_to_core_o  (gpio_to_core_o),
        .gpio_from_core_i(gpio_from_core_i),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] gpio;
        logic        ready;
        logic        rspv;
        logic        busy;
        logic [31:0] rdata;
        logic        rto;
    } exp_t;

    exp_t exp_q [MAXC];
    bit   exp_on [MAXC];

    int checks = 0;
    int errors = 0;

    // Model-held values that persist across transactions.
    logic [31:0] m_gpio  = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_rto   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%08h, required 0x%08h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input int n, input logic [31:0] g, input logic rdy,
                           input logic rv, input logic bz);
        if (n >= 0 && n < MAXC) begin
            exp_q[n]  = '{gpio: g, ready: rdy, rspv: rv, busy: bz, rdata: m_rdata, rto: m_rto};
            exp_on[n] = 1'b1;
        end
    endtask

    // Core model: echo word present from strobe-relative cycle off onward.
    function automatic logic [31:0] core_word(input int k, input int off, input logic [31:0] w);
        return (off >= 0 && k >= off) ? w : 32'h0;
    endfunction

    // ---------------- monitor + per-cycle compare ----------------
    int          strobe_rise_cyc = -100;
    int          strobe_fall_cyc = -100;
    int          rsp_rise_cyc    = -100;
    int          n_rises         = 0;
    int          crst_cycles     = 0;
    logic [31:0] rdata_at_rise   = 32'h0;
    logic        rto_at_rise     = 1'b0;
    logic        prev_strobe     = 1'b0;
    logic        prev_rspv       = 1'b0;

    always @(negedge clk) begin
        if (cyc < MAXC && exp_on[cyc]) begin
            check("gpio_to_core", gpio_to_core_o, exp_q[cyc].gpio);
            check("cmd_ready", 32'(host_if.cmd_ready_o), 32'(exp_q[cyc].ready));
            check("rsp_valid", 32'(host_if.rsp_valid_o), 32'(exp_q[cyc].rspv));
            check("busy", 32'(busy_o), 32'(exp_q[cyc].busy));
            if (exp_q[cyc].rspv) begin
                check("rsp_data", host_if.rsp_data_o, exp_q[cyc].rdata);
                check("rsp_timeout", 32'(host_if.rsp_timeout_o), 32'(exp_q[cyc].rto));
            end
        end
        if (gpio_to_core_o[30] === 1'b1 && !prev_strobe) begin
            n_rises++;
            if (n_rises > 1)
                check("strobe_low_gap_ge_L", 32'((cyc - strobe_fall_cyc) >= L), 32'd1);
            strobe_rise_cyc = cyc;
        end
        if (gpio_to_core_o[30] !== 1'b1 && prev_strobe) strobe_fall_cyc = cyc;
        if (host_if.rsp_valid_o === 1'b1 && !prev_rspv) begin
            rsp_rise_cyc  = cyc;
            rdata_at_rise = host_if.rsp_data_o;
            rto_at_rise   = host_if.rsp_timeout_o;
        end
        if (gpio_to_core_o === 32'h8000_0000) crst_cycles++;
        prev_strobe = (gpio_to_core_o[30] === 1'b1);
        prev_rspv   = (host_if.rsp_valid_o === 1'b1);
    end

    // ---------------- transaction tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i <= n; i++) set_exp(cyc + i, m_gpio, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [25:0] data, input int echo_off,
                           input logic [31:0] echo_word, input int rdy_dly);
        int          c, s, k, r;
        logic [31:0] g, word, w;
        logic        to;
        c = cyc;
        g = {2'b00, op, data};
        k = -1;
        for (int i = RD; i < TO; i++) begin
            w = core_word(i, echo_off, echo_word);
            if (k < 0 && w[31:28] == op) k = i;
        end
        to = (k < 0);
        if (to) k = TO - 1;
        word = core_word(k, echo_off, echo_word);
        s = c + L + 1;
        r = s + k + 1;
        set_exp(c, m_gpio, 1'b1, 1'b0, 1'b0);
        for (int n = c + 1; n < s; n++) set_exp(n, g, 1'b0, 1'b0, 1'b1);
        for (int n = s; n < r; n++) set_exp(n, {2'b01, op, data}, 1'b0, 1'b0, 1'b1);
        m_rdata = word;
        m_rto   = to;
        for (int n = r; n <= r + rdy_dly; n++) set_exp(n, g, 1'b0, 1'b1, 1'b1);
        m_gpio = g;
        set_exp(r + rdy_dly + 1, g, 1'b1, 1'b0, 1'b0);

        host_if.cmd_valid_i = 1'b1;
        host_if.cmd_op_i    = op;
        host_if.cmd_data_i  = data;
        while (cyc <= r + rdy_dly) begin
            host_if.rsp_ready_i = (cyc == r + rdy_dly);
            gpio_from_core_i    = (cyc >= s) ? core_word(cyc - s, echo_off, echo_word) : 32'h0;
            tick();
            host_if.cmd_valid_i = 1'b0;
        end
        host_if.rsp_ready_i = 1'b0;
        gpio_from_core_i    = 32'h0;
    endtask

    task automatic crst_then_cmd(input logic [3:0] op, input logic [25:0] data, input int echo_off,
                                 input logic [31:0] echo_word);
        int c;
        c = cyc;
        set_exp(c, m_gpio, 1'b1, 1'b0, 1'b0);
        for (int n = c + 1; n <= c + RH; n++) set_exp(n, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        m_gpio = 32'h0;
        core_rst_i          = 1'b1;
        host_if.cmd_valid_i = 1'b1;
        host_if.cmd_op_i    = op;
        host_if.cmd_data_i  = data;
        tick();
        core_rst_i = 1'b0;
        while (cyc < c + RH + 1) tick();
        run_cmd(op, data, echo_off, echo_word, 0);
    endtask

    task automatic reset_mid_strobe(input logic [3:0] op, input logic [25:0] data);
        int          c, s;
        logic [31:0] g;
        c = cyc;
        s = c + L + 1;
        g = {2'b00, op, data};
        set_exp(c, m_gpio, 1'b1, 1'b0, 1'b0);
        for (int n = c + 1; n < s; n++) set_exp(n, g, 1'b0, 1'b0, 1'b1);
        set_exp(s, {2'b01, op, data}, 1'b0, 1'b0, 1'b1);
        set_exp(s + 1, {2'b01, op, data}, 1'b0, 1'b0, 1'b1);
        m_gpio  = 32'h0;
        m_rdata = 32'h0;
        m_rto   = 1'b0;
        set_exp(s + 2, 32'h0, 1'b0, 1'b0, 1'b0);
        set_exp(s + 3, 32'h0, 1'b1, 1'b0, 1'b0);
        host_if.cmd_valid_i = 1'b1;
        host_if.cmd_op_i    = op;
        host_if.cmd_data_i  = data;
        tick();
        host_if.cmd_valid_i = 1'b0;
        while (cyc < s + 1) tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("rst_rsp_data", host_if.rsp_data_o, 32'h0);
        check("rst_rsp_timeout", 32'(host_if.rsp_timeout_o), 32'h0);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c1, crst0;
        host_if.cmd_valid_i = 1'b0;
        host_if.cmd_op_i    = 4'h0;
        host_if.cmd_data_i  = 26'h0;
        host_if.rsp_ready_i = 1'b0;

        for (int n = 1; n <= 3; n++) set_exp(n, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst_ni = 1'b1;
        tick();
        idle(2);

        // SET_LED with echo three cycles after the strobe rise.
        c1 = cyc;
        run_cmd(4'd1, 26'h00000A5, 3, 32'h1000_00A5, 0);
        check("req036_cmd_to_strobe", 32'(strobe_rise_cyc - c1), 32'd3);
        check("req036_strobe_to_rsp", 32'(rsp_rise_cyc - strobe_rise_cyc), 32'd5);
        check("req036_rsp_data", rdata_at_rise, 32'h1000_00A5);
        check("req036_rsp_timeout", 32'(rto_at_rise), 32'd0);

        // Back-to-back SET_DAC.
        c1 = n_rises;
        run_cmd(4'd2, 26'h0004ABC, 4, 32'h2000_4ABC, 0);
        check("req037_rsp1_data", rdata_at_rise, 32'h2000_4ABC);
        run_cmd(4'd2, 26'h0000123, 5, 32'h2000_0123, 0);
        check("req037_rsp2_data", rdata_at_rise, 32'h2000_0123);
        check("req037_two_rises", 32'(n_rises - c1), 32'd2);

        // GET_ADC with a silent core: timeout.
        run_cmd(4'd3, 26'h000003F, -1, 32'h0, 2);
        check("req038_strobe_to_rsp", 32'(rsp_rise_cyc - strobe_rise_cyc), 32'd16);
        check("req038_rsp_timeout", 32'(rto_at_rise), 32'd1);
        check("req038_rsp_data", rdata_at_rise, 32'h0);

        // Match arriving in the timeout cycle wins.
        run_cmd(4'd4, 26'h0000001, 15, 32'h4000_BEEF, 0);
        check("late_match_strobe_to_rsp", 32'(rsp_rise_cyc - strobe_rise_cyc), 32'd16);
        check("late_match_timeout", 32'(rto_at_rise), 32'd0);

        // Full-width payload, response held for 10 cycles.
        run_cmd(4'd5, 26'h3FFFFFF, 2, 32'h50AB_CDEF, 10);

        // Reset in the middle of STROBE.
        reset_mid_strobe(4'd6, 26'h0000155);
        idle(2);

        // Core reset and command together.
        crst0 = crst_cycles;
        crst_then_cmd(4'd1, 26'h0000077, 1, 32'h1000_0077);
        check("req040_crst_cycles", 32'(crst_cycles - crst0), 32'd4);
        check("req040_rsp_data", rdata_at_rise, 32'h1000_0077);
        idle(3);

        check("total_strobe_rises", 32'(n_rises), 32'd8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
